// File: rtl/retire_trace_buffer.sv
// Retirement trace FIFO: captures {pc, instr, rd, data} per retirement and streams each record as 4 beats.
// Latency: first beat valid the cycle after capture; full buffer drops new records (counted, sticky flag) unless a pop coincides.
module retire_trace_buffer #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic                     update_i,
   input  logic [XLEN-1:0]          pc_i,
   input  logic [XLEN-1:0]          instr_i,
   input  logic [4:0]               reg_addr_i,
   input  logic [XLEN-1:0]          reg_data_i,
   output logic                     tx_valid_o,
   input  logic                     tx_ready_i,
   output logic [XLEN-1:0]          tx_data_o,
   output logic                     tx_last_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [15:0]              drop_cnt_o,
   output logic                     overflow_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } rec_t;

   rec_t          mem [DEPTH];
   rec_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [1:0]    beat;
   logic          full;
   logic          xfer;
   logic          pop;
   logic          capture;
   logic          push;
   logic          drop;

   // A full buffer still accepts a record when the head's last beat leaves in the same cycle.
   always_comb begin
      full    = (count_o == FULL_CNT);
      xfer    = tx_valid_o & tx_ready_i;
      pop     = xfer & (beat == 2'd3);
      capture = update_i & enable_i;
      push    = capture & (~full | pop);
      drop    = capture & full & ~pop;
   end

   always_ff @(posedge clk_i) begin
      if (push && !rst_i) begin
         mem[wr_ptr] <= '{pc: pc_i, instr: instr_i, rd: reg_addr_i, data: reg_data_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         beat       <= '0;
         count_o    <= '0;
         drop_cnt_o <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         // Beat counter wraps 3 -> 0 exactly when the head record pops.
         if (xfer) begin
            beat <= beat + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count_o <= count_o + (AW+1)'(1);
         end else if (pop && !push) begin
            count_o <= count_o - (AW+1)'(1);
         end
         if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != 16'hFFFF) begin
               drop_cnt_o <= drop_cnt_o + 16'd1;
            end
         end
      end
   end

   always_comb begin
      head       = mem[rd_ptr];
      tx_valid_o = (count_o != '0);
      tx_data_o  = '0;
      tx_last_o  = 1'b0;
      if (tx_valid_o) begin
         tx_last_o = (beat == 2'd3);
         case (beat)
            2'd0:    tx_data_o = head.pc;
            2'd1:    tx_data_o = head.instr;
            2'd2:    tx_data_o = XLEN'(head.rd);
            default: tx_data_o = head.data;
         endcase
      end
   end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: vector table for single-record and backpressure timing,
// plus sequences for overflow, full-with-pop, pointer wrap and mid-record reset.
module tb_retire_trace_buffer;
   localparam int XLEN  = 32;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        update;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [4:0]  reg_addr;
   logic [31:0] reg_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] tx_data;
   logic        tx_last;
   logic [3:0]  count;
   logic [15:0] drop_cnt;
   logic        overflow;

   retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .update_i(update),
      .pc_i(pc), .instr_i(instr), .reg_addr_i(reg_addr), .reg_data_i(reg_data),
      .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data), .tx_last_o(tx_last),
      .count_o(count), .drop_cnt_o(drop_cnt), .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   bit          mon_on = 1'b0;
   logic [32:0] exp_q[$];
   logic [32:0] mon_e;

   typedef struct {
      logic        en;
      logic        upd;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        rdy;
      logic        ev;
      logic [31:0] ed;
      logic        el;
      logic [3:0]  ec;
   } vec_t;
   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic en, input logic upd, input logic [31:0] p, input logic [31:0] i,
                      input logic [4:0] r, input logic [31:0] d, input logic rdy,
                      input logic ev, input logic [31:0] ed, input logic el, input logic [3:0] ec);
      vec_t v;
      v.en = en; v.upd = upd; v.pc = p; v.instr = i; v.rd = r; v.data = d; v.rdy = rdy;
      v.ev = ev; v.ed = ed; v.el = el; v.ec = ec;
      vt.push_back(v);
   endtask

   task automatic drive(input logic en, input logic upd, input logic [31:0] p, input logic [31:0] i,
                        input logic [4:0] r, input logic [31:0] d, input logic rdy);
      @(negedge clk);
      enable = en; update = upd; pc = p; instr = i; reg_addr = r; reg_data = d; tx_ready = rdy;
   endtask

   task automatic push_rec(input logic [31:0] p, input logic [31:0] i, input logic [4:0] r,
                           input logic [31:0] d);
      exp_q.push_back({1'b0, p});
      exp_q.push_back({1'b0, i});
      exp_q.push_back({1'b0, 27'd0, r});
      exp_q.push_back({1'b1, d});
   endtask

   task automatic drain(input string name);
      for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
         drive(1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1);
      end
      #1;
      chk({name, "_beats_left"}, exp_q.size(), 0);
      chk({name, "_count"}, count, 0);
   endtask

   // Scoreboard: every accepted beat must match the next expected beat.
   always begin
      @(negedge clk);
      #4;
      if (mon_on && tx_valid === 1'b1 && tx_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got %h, expected no beat", tx_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("beat_data", tx_data, mon_e[31:0]);
            chk("beat_last", {31'd0, tx_last}, {31'd0, mon_e[32]});
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushed;
      // Reset with a retirement strobe held high: it must be ignored.
      rst = 1'b1; enable = 1'b1; update = 1'b1; tx_ready = 1'b1;
      pc = 32'h55; instr = 32'h66; reg_addr = 5'd7; reg_data = 32'h77;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; update = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_valid", tx_valid, 0);
      chk("rst_last", tx_last, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_ovf", overflow, 0);

      // Single record at full throughput.
      add(1, 1, 32'h100, 32'h0050_0093, 5'd1, 32'h5, 1, 0, 32'h0, 0, 4'd0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'h100, 0, 4'd1);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'h0050_0093, 0, 4'd1);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'h1, 0, 4'd1);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'h5, 1, 4'd1);
      add(1, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 4'd0);
      // Backpressure for 10 cycles after beat1 is presented, then a stall on beat2.
      add(1, 1, 32'h200, 32'h0050_0093, 5'd31, 32'h77, 0, 0, 32'h0, 0, 4'd0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'h200, 0, 4'd1);
      for (int k = 0; k < 10; k++) add(1, 0, 0, 0, 0, 0, 0, 1, 32'h0050_0093, 0, 4'd1);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'h0050_0093, 0, 4'd1);
      add(1, 0, 0, 0, 0, 0, 0, 1, 32'h1F, 0, 4'd1);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'h1F, 0, 4'd1);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'h77, 1, 4'd1);
      // Capture disabled: retirement ignored, ready while idle has no effect.
      add(0, 1, 32'h999, 32'h999, 5'd9, 32'h999, 1, 0, 32'h0, 0, 4'd0);
      add(1, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 4'd0);
      // Two records back to back; enable drops mid-record without stalling the stream.
      add(1, 1, 32'h300, 32'hAAAA_5555, 5'd2, 32'hDEAD_BEEF, 1, 0, 32'h0, 0, 4'd0);
      add(1, 1, 32'h304, 32'h11, 5'd3, 32'h22, 1, 1, 32'h300, 0, 4'd1);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'hAAAA_5555, 0, 4'd2);
      add(0, 1, 32'h888, 32'h888, 5'd8, 32'h888, 1, 1, 32'h2, 0, 4'd2);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 1, 4'd2);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'h304, 0, 4'd1);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'h11, 0, 4'd1);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'h3, 0, 4'd1);
      add(1, 0, 0, 0, 0, 0, 1, 1, 32'h22, 1, 4'd1);
      add(1, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 4'd0);

      for (int k = 0; k < vt.size(); k++) begin
         drive(vt[k].en, vt[k].upd, vt[k].pc, vt[k].instr, vt[k].rd, vt[k].data, vt[k].rdy);
         #1;
         chk($sformatf("vec%0d_valid", k), tx_valid, vt[k].ev);
         chk($sformatf("vec%0d_data", k), tx_data, vt[k].ed);
         chk($sformatf("vec%0d_last", k), tx_last, vt[k].el);
         chk($sformatf("vec%0d_count", k), count, vt[k].ec);
      end
      chk("vec_drop", drop_cnt, 0);
      chk("vec_ovf", overflow, 0);

      // Overflow: 11 retirements into a stalled buffer keep the first 8.
      mon_on = 1'b1;
      for (int i = 0; i < 11; i++) begin
         drive(1, 1, 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 5'(i), ~32'(i), 0);
         if (i < 8) push_rec(32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 5'(i), ~32'(i));
      end
      drive(1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("ovf_count", count, 8);
      chk("ovf_drop", drop_cnt, 3);
      chk("ovf_flag", overflow, 1);
      drain("ovf");
      chk("ovf_drop_kept", drop_cnt, 3);

      // Full buffer: new record arrives on the head's beat3 handshake.
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 32'h2000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 5'(i + 8), 32'hC0 + 32'(i), 0);
         push_rec(32'h2000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 5'(i + 8), 32'hC0 + 32'(i));
      end
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 1);
      drive(1, 1, 32'h2F00, 32'hBEEF_0001, 5'd30, 32'h1234_5678, 1);
      push_rec(32'h2F00, 32'hBEEF_0001, 5'd30, 32'h1234_5678);
      #1;
      chk("fullpop_last", tx_last, 1);
      drive(1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("fullpop_count", count, 8);
      chk("fullpop_drop", drop_cnt, 3);
      drain("fullpop");

      // Pointer wrap: 20 records, pushed whenever there is room, ready toggling.
      pushed = 0;
      for (int c = 0; c < 1000 && pushed < 20; c++) begin
         @(negedge clk);
         tx_ready = c[0];
         enable = 1'b1;
         if (count < 4'(DEPTH)) begin
            update = 1'b1;
            pc = 32'h4000 + 32'(pushed * 8); instr = 32'hD000_0000 + 32'(pushed);
            reg_addr = 5'(31 - pushed); reg_data = 32'hE000 + 32'(pushed);
            push_rec(pc, instr, reg_addr, reg_data);
            pushed++;
         end else begin
            update = 1'b0;
         end
      end
      chk("wrap_pushed", pushed, 20);
      drain("wrap");
      chk("wrap_drop", drop_cnt, 3);

      // Reset after beat1 abandons the rest of the record.
      mon_on = 1'b0;
      drive(1, 1, 32'h5000, 32'h5111, 5'd4, 32'h5222, 1);
      drive(1, 0, 0, 0, 0, 0, 1);
      #1;
      chk("mid_beat0", tx_data, 32'h5000);
      drive(1, 0, 0, 0, 0, 0, 1);
      #1;
      chk("mid_beat1", tx_data, 32'h5111);
      @(negedge clk);
      rst = 1'b1; update = 1'b1; pc = 32'h6666;
      @(negedge clk);
      rst = 1'b0; update = 1'b0;
      #1;
      chk("mid_valid", tx_valid, 0);
      chk("mid_count", count, 0);
      chk("mid_drop", drop_cnt, 0);
      chk("mid_ovf", overflow, 0);
      chk("mid_data", tx_data, 0);
      drive(1, 1, 32'h7000, 32'h7111, 5'd6, 32'h7222, 1);
      drive(1, 0, 0, 0, 0, 0, 1);
      #1;
      chk("post_valid", tx_valid, 1);
      chk("post_beat0", tx_data, 32'h7000);
      drive(1, 0, 0, 0, 0, 0, 1);
      #1;
      chk("post_beat1", tx_data, 32'h7111);
      drive(1, 0, 0, 0, 0, 0, 1);
      #1;
      chk("post_beat2", tx_data, 32'h6);
      drive(1, 0, 0, 0, 0, 0, 1);
      #1;
      chk("post_beat3", tx_data, 32'h7222);
      chk("post_last", tx_last, 1);
      drive(1, 0, 0, 0, 0, 0, 1);
      #1;
      chk("post_empty", tx_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
